// File: rtl/rr_arb64_pkg.sv
// Shared constants for the 64-way round-robin arbiter: requester count,
// index width and FSM state encodings.
package rr_arb64_pkg;

  localparam int N_REQ = 64;
  localparam int IDX_W = 6;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_arb64_dec6to64.sv
// 6-to-64 one-hot decoder built from two 3-to-8 pre-decoders whose
// outputs are combined as an 8x8 AND matrix.
module dec6to64 (
  input  logic [5:0]  idx,
  output logic [63:0] onehot
);

  logic [7:0]  lo_dec;
  logic [7:0]  hi_dec;
  logic [63:0] hi_rep;

  always_comb begin
    lo_dec = '0;
    hi_dec = '0;
    lo_dec[idx[2:0]] = 1'b1;
    hi_dec[idx[5:3]] = 1'b1;
  end

  // Each high-group line covers one contiguous byte of the output.
  for (genvar g = 0; g < 8; g++) begin : g_hi_rep
    assign hi_rep[8*g +: 8] = {8{hi_dec[g]}};
  end

  assign onehot = {8{lo_dec}} & hi_rep;

endmodule

// File: rtl/rr_arb64.sv
// Round-robin arbiter for 64 requesters: holds each grant until a
// valid/ready handshake, then re-arbitrates in the same cycle.
module rr_arb64
  import rr_arb64_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [rr_arb64_pkg::N_REQ-1:0] req,
  input  logic                          gnt_ready,
  output logic                          gnt_valid,
  output logic [rr_arb64_pkg::IDX_W-1:0] gnt_idx,
  output logic [rr_arb64_pkg::N_REQ-1:0] gnt_onehot,
  output logic                          busy
);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             handshake;
  logic             any_req;
  logic [IDX_W-1:0] search_base;
  logic [IDX_W-1:0] pick;
  logic [N_REQ-1:0] dec_onehot;

  // First set bit at or after base, wrapping modulo 64: rotate right by
  // base, find the lowest set bit, then add base back.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [IDX_W-1:0] base
  );
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    dbl = {r, r} >> base;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return off + base;
  endfunction

  assign handshake = (state == ST_GRANT) && gnt_ready;
  assign any_req   = |req;
  // On a handshake the pointer update is bypassed so the next grant needs no bubble.
  assign search_base = handshake ? gnt_idx_q + 1'b1 : ptr;
  assign pick        = rr_pick(req, search_base);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt_idx_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state     <= ST_GRANT;
            gnt_idx_q <= pick;
          end
        end
        default: begin
          if (handshake) begin
            ptr <= gnt_idx_q + 1'b1;
            if (any_req) gnt_idx_q <= pick;
            else         state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign gnt_valid = (state == ST_GRANT);
  assign busy      = gnt_valid;
  assign gnt_idx   = gnt_idx_q;

  dec6to64 u_dec (
    .idx    (gnt_idx_q),
    .onehot (dec_onehot)
  );

  assign gnt_onehot = dec_onehot & {N_REQ{gnt_valid}};

endmodule

// File: tb/tb_rr_arb64.sv
// Directed bench for rr_arb64: expected grants are queued by the stimulus
// and a negedge monitor pops and compares them at each handshake.
module tb_rr_arb64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] req = '0;
  logic        gnt_ready = 1'b0;
  logic        gnt_valid;
  logic [5:0]  gnt_idx;
  logic [63:0] gnt_onehot;
  logic        busy;

  int          tests = 0;
  int          fails = 0;
  int unsigned exp_q[$];

  rr_arb64 dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},  64'(gnt_valid),  64'd0);
    check({tag, "_busy"},   64'(busy),       64'd0);
    check({tag, "_onehot"}, gnt_onehot,      64'd0);
  endtask

  task automatic check_grant(input string tag, input int idx);
    check({tag, "_valid"},  64'(gnt_valid), 64'd1);
    check({tag, "_busy"},   64'(busy),      64'd1);
    check({tag, "_idx"},    64'(gnt_idx),   64'(idx));
    check({tag, "_onehot"}, gnt_onehot,     64'd1 << idx);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive r with gnt_ready high for n back-to-back grants, then drop req.
  task automatic stream(input logic [63:0] r, input int n, input string tag);
    req       = r;
    gnt_ready = 1'b1;
    tick();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check({tag, "_continuous"}, 64'(gnt_valid), 64'd1);
      if (k == n - 1) req = '0;
      tick();
    end
    gnt_ready = 1'b0;
    @(negedge clk);
    check_idle({tag, "_end"});
  endtask

  // Scoreboard monitor: every handshake must match the next queued grant.
  always @(negedge clk) begin
    int unsigned e;
    if (!rst && gnt_valid && gnt_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got idx %0d expected none", gnt_idx);
      end else begin
        e = exp_q.pop_front();
        check("sb_idx",    64'(gnt_idx), 64'(e));
        check("sb_onehot", gnt_onehot,   64'd1 << e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: outputs zero before and during clocking with rst high.
    #1 rst = 1'b1;
    #2;
    check_idle("rst_async");
    check("rst_idx", 64'(gnt_idx), 64'd0);
    repeat (2) tick();
    @(negedge clk);
    check_idle("rst_held");
    tick();
    rst = 1'b0;

    // Single request, held without ready, then released to IDLE.
    req       = 64'h1;
    gnt_ready = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_grant("single", 0);
      tick();
    end
    exp_q.push_back(0);
    gnt_ready = 1'b1;
    req       = '0;
    tick();
    gnt_ready = 1'b0;
    @(negedge clk);
    check_idle("single_idle");

    // Rotation among 3, 10, 40 (pointer now 1).
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(3);  exp_q.push_back(10); exp_q.push_back(40);
    exp_q.push_back(3);  exp_q.push_back(10); exp_q.push_back(40);
    stream((64'd1 << 3) | (64'd1 << 10) | (64'd1 << 40), 6, "rot");

    // Wrap-around: pointer 41, requesters 63 and 0.
    exp_q.push_back(63); exp_q.push_back(0); exp_q.push_back(63);
    stream((64'd1 << 63) | 64'd1, 3, "wrap");

    // Hold and no retraction: grant 5, ready low 4 cycles, req dropped in cycle 2.
    req       = 64'd1 << 5;
    gnt_ready = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("hold_idx",  64'(gnt_idx), 64'd5);
      check("hold_bit5", 64'(gnt_onehot[5]), 64'd1);
      if (c == 1) req = '0;
      tick();
    end
    exp_q.push_back(5);
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    @(negedge clk);
    check_idle("hold_idle");

    // Sole requester is re-granted every cycle without a gap.
    repeat (4) exp_q.push_back(20);
    stream(64'd1 << 20, 4, "sole");

    // Asynchronous reset mid-grant (pointer 21 before the pulse).
    req       = 64'd1 << 17;
    gnt_ready = 1'b0;
    tick();
    @(negedge clk);
    check_grant("pre_rst", 17);
    #2 rst = 1'b1;
    #1;
    check_idle("mid_rst");
    check("mid_rst_idx", 64'(gnt_idx), 64'd0);
    // With ptr back at 0, 17 must win over 30.
    req = req | (64'd1 << 30);
    #1 rst = 1'b0;
    tick();
    @(negedge clk);
    check_grant("post_rst", 17);
    tick();
    exp_q.push_back(17);
    gnt_ready = 1'b1;
    req       = '0;
    @(negedge clk);
    tick();
    gnt_ready = 1'b0;
    @(negedge clk);
    check_idle("post_rst_idle");

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
